// File: rtl/vexp_sum_buf_bf16.sv
// Row buffer and bf16 sum accumulator for the vector softmax path.
// Buffers one row of bf16 exp results, sums them through a shared external
// adder (request/response), then replays the row together with the final sum.
module vexp_sum_buf_bf16 #(
  parameter int DEPTH = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_valid_in,
  input  logic [15:0] add_out,
  input  logic        add_valid_out,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [15:0] out_sum,
  output logic        out_last,
  input  logic        out_ready,
  output logic        sum_inf,
  output logic        truncated
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {ACC, ADD, WAIT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [15:0]     sum;
  logic [15:0]     cur;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd;
  logic            last_seen;
  logic            trunc_q;

  logic accept;
  logic add_done;
  logic drain_hs;
  logic last_beat;

  assign accept    = in_valid && in_ready;
  assign add_done  = ((state == ADD) || (state == WAIT)) && add_valid_out;
  assign drain_hs  = (state == DRAIN) && out_ready;
  assign last_beat = ({1'b0, rd} == (count - ONE));
  assign sum_inf   = (sum[14:7] == 8'hFF);
  assign truncated = trunc_q;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ACC;
    else       state <= state_nxt;
  end

  // Next-state decision: accept, request the add, wait for the result, drain.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:   if (in_valid) state_nxt = ADD;
      ADD,
      WAIT: begin
        if (add_valid_out) begin
          if (last_seen || (count == FULL)) state_nxt = DRAIN;
          else                              state_nxt = ACC;
        end else begin
          state_nxt = WAIT;
        end
      end
      DRAIN: if (out_ready && last_beat) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Output decode; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready     = 1'b0;
    add_a        = 16'h0000;
    add_b        = 16'h0000;
    add_valid_in = 1'b0;
    out_valid    = 1'b0;
    out_data     = 16'h0000;
    out_sum      = 16'h0000;
    out_last     = 1'b0;
    case (state)
      ACC:   in_ready = nRST;
      ADD: begin
        add_valid_in = 1'b1;
        add_a        = sum;
        add_b        = cur;
      end
      WAIT: begin
        add_a = sum;
        add_b = cur;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[rd];
        out_sum   = sum;
        out_last  = last_beat;
      end
      default: ;
    endcase
  end

  // Row bookkeeping: element capture, sum update, replay pointer and row clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sum       <= 16'h0000;
      cur       <= 16'h0000;
      count     <= '0;
      rd        <= '0;
      last_seen <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      if (accept) begin
        cur       <= in_data;
        count     <= count + ONE;
        last_seen <= in_last;
      end
      if (add_done) begin
        sum <= add_out;
        if (!last_seen && (count == FULL)) trunc_q <= 1'b1;
      end
      if (drain_hs) begin
        if (last_beat) begin
          sum       <= 16'h0000;
          count     <= '0;
          rd        <= '0;
          last_seen <= 1'b0;
          trunc_q   <= 1'b0;
        end else begin
          rd <= rd + 1'b1;
        end
      end
    end
  end

  // Element storage, written in arrival order.
  // NOTE: the buffer has no reset; count/rd are cleared, so stale entries are never read.
  always_ff @(posedge CLK) begin
    if (accept) mem[count[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_vexp_sum_buf_bf16.sv
// Self-checking bench for vexp_sum_buf_bf16: stub bf16 adder with variable
// latency, row-level reference model, per-cycle compare process.
module tb_vexp_sum_buf_bf16;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] add_a, add_b;
  logic        add_valid_in;
  logic [15:0] add_out;
  logic        add_valid_out;
  logic        out_valid;
  logic [15:0] out_data, out_sum;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        sum_inf, truncated;

  int checks = 0;
  int errors = 0;

  vexp_sum_buf_bf16 #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_valid_in(add_valid_in),
    .add_out(add_out), .add_valid_out(add_valid_out),
    .out_valid(out_valid), .out_data(out_data), .out_sum(out_sum),
    .out_last(out_last), .out_ready(out_ready),
    .sum_inf(sum_inf), .truncated(truncated)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bf16 arithmetic via double precision ----------------
  function automatic real bf2r(input logic [15:0] x);
    logic [63:0] d;
    if (x[14:7] == 8'h00) return 0.0;
    if (x[14:7] == 8'hFF) d = {x[15], 11'h7FF, x[6:0], 45'd0};
    else                  d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    int be;
    d = $realtobits(r);
    if (d[62:52] == 11'h000) return {d[63], 15'd0};
    if (d[62:52] == 11'h7FF) return (d[51:0] != 0) ? 16'h7FC0 : {d[63], 8'hFF, 7'd0};
    be = int'(d[62:52]) - 896;
    if (be >= 255) return {d[63], 8'hFF, 7'd0};
    if (be <= 0)   return {d[63], 15'd0};
    return {d[63], be[7:0], d[51:45]};
  endfunction

  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    return r2bf(bf2r(a) + bf2r(b));
  endfunction

  // ---------------- stub adder with latency lat (0 = same cycle) ----------------
  int          lat = 2;
  int          cnt = 0;
  logic [15:0] res = 16'h0000;
  logic        spur = 1'b0;
  logic        spur_en = 1'b0;
  logic        spur_hit;

  assign spur_hit = spur && out_valid;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= 0;
      res <= 16'h0000;
    end else if (add_valid_in && lat > 0) begin
      cnt <= lat;
      res <= bf16_add(add_a, add_b);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  always @* begin
    add_valid_out = ((lat == 0) ? add_valid_in : (cnt == 1)) | spur_hit;
    if (spur_hit)      add_out = 16'h1234;
    else if (lat == 0) add_out = bf16_add(add_a, add_b);
    else               add_out = res;
  end

  // Spurious adder responses (only while draining), must be ignored.
  initial forever begin
    @(posedge CLK); #1;
    spur = spur_en && ($urandom_range(3) == 0);
  end

  // Downstream ready: 0 always, 1 random, 2 pattern 1,0,0 repeating.
  int rmode = 0;
  int pcnt = 0;
  initial forever begin
    @(posedge CLK); #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(1) == 1);
      default: begin
        out_ready = (pcnt == 0);
        pcnt = (pcnt + 1) % 3;
      end
    endcase
  end

  // ---------------- reference model + compare process ----------------
  typedef enum int {M_ACC, M_BUSY, M_DRAIN} mphase_t;
  mphase_t     ph = M_ACC;
  logic [15:0] row_q[$];
  logic [15:0] d_row[$];
  logic [15:0] run_sum = 16'h0000;
  logic [15:0] b_elem, b_sum, d_sum;
  logic        b_done, b_trunc, d_trunc;
  int          b_lat, busy_start, beat, cyc = 0;
  logic [15:0] last_sum = 16'h0000;
  logic        last_trunc = 1'b0, last_inf = 1'b0;
  int          last_len = 0, rows_done = 0;

  always @(negedge CLK) begin
    int c;
    cyc++;
    if (!nRST) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_add_valid_in", add_valid_in, 0);
      check("rst_add_ab", {add_a, add_b}, 0);
      check("rst_out_data_sum", {out_data, out_sum}, 0);
      check("rst_flags", {sum_inf, truncated}, 0);
      ph = M_ACC;
      row_q.delete();
      run_sum = 16'h0000;
    end else begin
      if (ph == M_BUSY) begin
        c = cyc - busy_start;
        if (c <= b_lat + 1) begin
          check("add_valid_in", add_valid_in, (c == 1) ? 1 : 0);
          check("add_a", add_a, run_sum);
          check("add_b", add_b, b_elem);
          check("busy_in_ready", in_ready, 0);
          check("busy_out_valid", out_valid, 0);
        end else begin
          run_sum = b_sum;
          if (b_done) begin
            d_row   = row_q;
            row_q.delete();
            d_sum   = run_sum;
            d_trunc = b_trunc;
            beat    = 0;
            run_sum = 16'h0000;
            ph      = M_DRAIN;
          end else begin
            ph = M_ACC;
          end
        end
      end
      if (ph == M_ACC) begin
        check("acc_in_ready", in_ready, 1);
        check("acc_out_valid", out_valid, 0);
        check("acc_add_valid_in", add_valid_in, 0);
        check("acc_add_ab", {add_a, add_b}, 0);
        if (in_valid) begin
          row_q.push_back(in_data);
          b_elem     = in_data;
          b_sum      = bf16_add(run_sum, in_data);
          b_done     = in_last || (row_q.size() == DEPTH);
          b_trunc    = !in_last && (row_q.size() == DEPTH);
          b_lat      = lat;
          busy_start = cyc;
          ph         = M_BUSY;
        end
      end else if (ph == M_DRAIN) begin
        check("drn_out_valid", out_valid, 1);
        check("drn_in_ready", in_ready, 0);
        check("drn_add_valid_in", add_valid_in, 0);
        check("drn_out_data", out_data, d_row[beat]);
        check("drn_out_sum", out_sum, d_sum);
        check("drn_out_last", out_last, (beat == d_row.size() - 1) ? 1 : 0);
        check("drn_sum_inf", sum_inf, (d_sum[14:7] == 8'hFF) ? 1 : 0);
        check("drn_truncated", truncated, d_trunc);
        if (out_ready) begin
          beat++;
          if (beat == d_row.size()) begin
            last_sum   = d_sum;
            last_trunc = d_trunc;
            last_inf   = (d_sum[14:7] == 8'hFF);
            last_len   = beat;
            rows_done++;
            ph = M_ACC;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] elems [DEPTH];

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_row(input int n, input logic with_last);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(2)) begin @(posedge CLK); #1; end
      send(elems[i], with_last && (i == n - 1));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(posedge CLK); #2;
      if (ph == M_ACC && in_ready && row_q.size() == 0) break;
      n++;
      if (n > 2000) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  function automatic logic [15:0] rand_bf16();
    logic [7:0] e;
    e = 8'(110 + $urandom_range(30));
    return {1'($urandom_range(1)), e, 7'($urandom_range(127))};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt_before;
    logic wl;

    // Model pins.
    check("pin_1p1", bf16_add(16'h3F80, 16'h3F80), 16'h4000);
    check("pin_3p3", bf16_add(16'h4040, 16'h4040), 16'h40C0);
    check("pin_ovf", bf16_add(16'h7F00, 16'h7F00), 16'h7F80);

    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    // Four 1.0 elements, L=2.
    lat = 2; rmode = 0;
    for (int i = 0; i < 4; i++) elems[i] = 16'h3F80;
    send_row(4, 1'b1);
    wait_idle();
    check("t1_sum", last_sum, 16'h4080);
    check("t1_len", last_len, 4);
    check("t1_flags", {last_inf, last_trunc}, 0);

    // 1,2,3 with L=0.
    lat = 0;
    elems[0] = 16'h3F80; elems[1] = 16'h4000; elems[2] = 16'h4040;
    send_row(3, 1'b1);
    wait_idle();
    check("t2_sum", last_sum, 16'h40C0);

    // DEPTH elements without in_last -> truncated.
    lat = 1; rmode = 1;
    for (int i = 0; i < DEPTH; i++) elems[i] = 16'h3F80;
    send_row(DEPTH, 1'b0);
    wait_idle();
    check("t3_trunc", last_trunc, 1);
    check("t3_len", last_len, DEPTH);
    check("t3_sum", last_sum, 16'h4180);

    // DEPTH elements with in_last on the last one -> not truncated.
    send_row(DEPTH, 1'b1);
    wait_idle();
    check("t3b_trunc", last_trunc, 0);
    check("t3b_len", last_len, DEPTH);

    // Stalling drain pattern 1,0,0.
    rmode = 2; lat = 3;
    for (int i = 0; i < 5; i++) elems[i] = rand_bf16();
    send_row(5, 1'b1);
    wait_idle();
    check("t4_len", last_len, 5);

    // Overflow to infinity.
    rmode = 0; lat = 1;
    elems[0] = 16'h7F00; elems[1] = 16'h7F00;
    send_row(2, 1'b1);
    wait_idle();
    check("t5_sum", last_sum, 16'h7F80);
    check("t5_inf", last_inf, 1);

    // Reset mid-drain at rd=2.
    lat = 2; rmode = 0;
    for (int i = 0; i < 4; i++) elems[i] = 16'h4000;
    cnt_before = rows_done;
    send_row(4, 1'b1);
    n = 0;
    forever begin
      @(posedge CLK); #2;
      if (ph == M_DRAIN && beat == 2) break;
      n++;
      if (n > 500) begin
        check("t6_timeout", 0, 1);
        break;
      end
    end
    nRST = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_data_sum", {out_data, out_sum}, 0);
    check("t6_last_trunc", {out_last, truncated}, 0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    check("t6_no_complete", rows_done, cnt_before);
    elems[0] = 16'h3F80;
    send_row(1, 1'b1);
    wait_idle();
    check("t6_sum", last_sum, 16'h3F80);
    check("t6_len", last_len, 1);

    // Randomized rows with spurious adder responses during drain.
    spur_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      lat   = $urandom_range(3);
      rmode = $urandom_range(2);
      n     = 1 + $urandom_range(DEPTH - 1);
      wl    = ($urandom_range(4) != 0);
      if (!wl) n = DEPTH;
      for (int i = 0; i < n; i++) elems[i] = rand_bf16();
      cnt_before = rows_done;
      send_row(n, wl);
      wait_idle();
      check("rnd_row_done", rows_done, cnt_before + 1);
      check("rnd_len", last_len, n);
      check("rnd_trunc", last_trunc, !wl);
    end
    spur_en = 1'b0;

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vexp_sum_buf_bf16.md
# vexp_sum_buf_bf16

Downstream companion of the bf16 exponential FSM in the vector softmax path. It accepts the stream of bf16 exp results for one row, buffers them, and accumulates their bf16 sum (the softmax denominator) through the shared external adder using the same request/response style as the exp FSM. When the row is complete it replays every buffered element alongside the final sum, so a later divide stage can normalise the row.

## Interface
- DEPTH, 16: maximum elements per row; buffer entries; power of two, ≥2.
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  exp result valid.
- in_data  input  16  bf16 exp result.
- in_last  input  1  marks final element of row.
- in_ready  output  1  element accepted when in_valid && in_ready.
- add_a  output  16  adder operand A (running sum).
- add_b  output  16  adder operand B (new element).
- add_valid_in  output  1  one-cycle add request pulse.
- add_out  input  16  adder bf16 result.
- add_valid_out  input  1  add_out valid; one pulse per request.
- out_valid  output  1  replay element valid.
- out_data  output  16  buffered element, arrival order.
- out_sum  output  16  final bf16 row sum; stable for whole drain.
- out_last  output  1  high with the last replayed element.
- out_ready  input  1  downstream consumes when out_valid && out_ready.
- sum_inf  output  1  out_sum exponent field is 8'hFF (inf/NaN); valid during drain.
- truncated  output  1  row hit DEPTH without in_last; valid during drain.

## Operation
- States: ACC, ADD, WAIT, DRAIN.
- Registers: buf[DEPTH] x16, sum (16), cur (16), count (log2(DEPTH)+1), rd ptr, last_seen, truncated.
- ACC: in_ready=1. On accept: buf[count]<=in_data, cur<=in_data, count<=count+1, last_seen<=in_last; go ADD.
- ADD: add_valid_in=1 for exactly this cycle; add_a=sum, add_b=cur. If add_valid_out is high this cycle, handle as in WAIT; otherwise go WAIT.
- WAIT: add_a/add_b held equal to the ADD values; add_valid_in=0. On add_valid_out: sum<=add_out. Then:
  - last_seen: go DRAIN.
  - count==DEPTH: set truncated, go DRAIN.
  - otherwise: go ACC.
- The first element is added to sum=16'h0000, so every element uses the same path.
- DRAIN: out_valid=1, out_data=buf[rd], out_sum=sum, out_last=(rd==count-1). On handshake rd<=rd+1. On the handshake with out_last: clear sum, count, rd, last_seen and truncated, then go ACC.
- No arithmetic is done locally. sum_inf is the combinational test sum[14:7]==8'hFF.
- Outside ACC: in_ready=0. Outside DRAIN: out_valid=0 and out_last=0. add_a/add_b are 0 outside ADD/WAIT.
- An add_valid_out pulse outside ADD/WAIT is ignored.

## Timing
- Reset (async, nRST low): state=ACC, all registers 0.
  - All outputs are 0, with in_ready forced 0 while nRST is low.
  - in_ready rises on the first edge-free cycle after release.
- Per element: 1 accept cycle + 1 ADD cycle + adder latency L (≥0 extra WAIT cycles).
  - Next in_ready is asserted the cycle after the add_valid_out cycle.
  - Throughput is one element per L+2 cycles.
- Drain begins the cycle after the final add_valid_out. Each element takes 1 cycle when out_ready=1.
- out_data and out_sum are held stable while out_valid && !out_ready.
- A reset in any state aborts the row. Buffer contents are discarded and no partial drain resumes.
- in_last on element DEPTH: treated as a normal last; truncated stays 0.
- Single-element row (in_last on first element): sum = element; drain has one beat with out_last=1.

## Test plan
- Four elements 16'h3F80 (1.0), last on the 4th, stub adder L=2 -> out_sum=16'h4080 (4.0). Replay is 3F80 x4 with out_last on beat 4; sum_inf=0; truncated=0.
- Elements 16'h3F80, 16'h4000, 16'h4040 (1,2,3), L=0 (add_valid_out during ADD) -> sum 16'h40C0. Each in_ready gap is exactly 2 cycles.
- DEPTH=16 elements with no in_last -> truncated=1. Exactly 16 beats are replayed; in_ready stays 0 until the final out_last handshake.
- Drain with out_ready toggling 1,0,0,1… -> out_data/out_sum stable while stalled. No element is skipped or duplicated, and the next row starts with sum=0.
- Two elements 16'h7F00 -> stub adder returns 16'h7F80. sum_inf=1 during drain.
- Assert nRST mid-drain at rd=2 -> all outputs are 0 immediately. After release, a new 1-element row 16'h3F80 yields out_sum=16'h3F80.
